// File: rtl/div_unit_pkg.sv
// Shared widths, constants and FSM encodings for the radix-2 divider.
// Operand width defaults to 32; the result bus is twice that.
// Imported by div_unit and available to the HI/LO write path.
package div_unit_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 2 * REG_BUS;

  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: trial-subtract divisor from the shifted partial remainder.
// Purely combinational; the caller supplies the already-shifted remainder (DATA_W+1 bits).
// quo_bit=1 means the subtraction was kept, otherwise the remainder is restored.
module div_sub_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   rem_hi,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              quo_bit
);

  // Trial subtraction; the shifted remainder is always below 2*divisor, so a kept
  // difference always fits back into DATA_W bits.
  always_comb begin
    quo_bit  = (rem_hi >= {1'b0, divisor});
    rem_next = quo_bit ? DATA_W'(rem_hi - {1'b0, divisor}) : rem_hi[DATA_W-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) feeding HI/LO: result_o = {rem, quo}.
// Latency: DATA_W cycles from the launch edge (1 cycle for a zero divisor); ready_o pulses once.
// No backpressure: start_i is only honoured while idle; busy_o stalls EX. Option macro: DIV_ANNUL_EN.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = REG_BUS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  div_state_t state, state_n;

  logic [CNT_W-1:0]  counter;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] divisor_q;
  logic              sign_q;
  logic              sign_r;
  logic              signed_q;

  logic [DATA_W-1:0] op1_mag;
  logic [DATA_W-1:0] op2_mag;
  logic [DATA_W-1:0] step_rem;
  logic              step_bit;
  logic [DATA_W-1:0] quo_raw;
  logic [DATA_W-1:0] quo_fin;
  logic [DATA_W-1:0] rem_fin;

`ifndef DIV_ANNUL_EN
  logic annul_unused;
  assign annul_unused = annul_i;
`endif

  div_sub_step #(.DATA_W(DATA_W)) u_step (
    .rem_hi   ({rem_q, quo_q[DATA_W-1]}),
    .divisor  (divisor_q),
    .rem_next (step_rem),
    .quo_bit  (step_bit)
  );

  // Operand magnitudes at launch and sign-corrected result of the final step.
  // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
  always_comb begin
    op1_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    op2_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    quo_raw = {quo_q[DATA_W-2:0], step_bit};
    quo_fin = (signed_q && sign_q) ? -quo_raw : quo_raw;
    rem_fin = (signed_q && sign_r) ? -step_rem : step_rem;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DIV_FREE;
    else     state <= state_n;
  end

  // Next-state logic; an annul during a running division drops straight back to idle.
  always_comb begin
    state_n = state;
    case (state)
      DIV_FREE:    if (start_i) state_n = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
      DIV_BY_ZERO: state_n = DIV_END;
      DIV_ON:      if (counter == LAST_CNT) state_n = DIV_END;
      DIV_END:     state_n = DIV_FREE;
      default:     state_n = DIV_FREE;
    endcase
`ifdef DIV_ANNUL_EN
    if (annul_i && (state == DIV_BY_ZERO || state == DIV_ON)) state_n = DIV_FREE;
`endif
  end

  // Datapath, step counter and registered outputs; result_o only changes on END entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      signed_q  <= 1'b0;
      result_o  <= '0;
      ready_o   <= DIV_RESULT_NOT_READY;
      busy_o    <= 1'b0;
    end else begin
      ready_o <= (state_n == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
      busy_o  <= (state_n == DIV_BY_ZERO) || (state_n == DIV_ON);
      case (state)
        DIV_FREE: begin
          if (start_i) begin
            counter   <= '0;
            rem_q     <= '0;
            quo_q     <= op1_mag;
            divisor_q <= op2_mag;
            sign_q    <= opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1];
            sign_r    <= opdata1_i[DATA_W-1];
            signed_q  <= signed_div_i;
          end
        end
        DIV_ON: begin
          rem_q   <= step_rem;
          quo_q   <= quo_raw;
          counter <= counter + CNT_W'(1);
        end
        default: ;
      endcase
      if (state_n == DIV_END) begin
        result_o <= (state == DIV_ON) ? {rem_fin, quo_fin} : '0;
      end
    end
  end

endmodule
